// File: rtl/pixel_ctrl_pkg.sv
// Shared types and helpers for the pixel readout sequencer.
// Gray/binary helpers work on 32-bit values; callers zero-extend and truncate.
package pixel_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_GAP     = 3'd4,
    ST_RD_SEL  = 3'd5,
    ST_RD_CAP  = 3'd6,
    ST_RD_HOLD = 3'd7
  } state_e;

  // Binary to reflected Gray code
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code back to binary (prefix XOR from the MSB down)
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/pixel_conv_counter.sv
// Saturating N-bit conversion counter with clear/enable and terminal-count flag.
// code_nxt_c is the (optionally Gray-encoded, GRAY_COUNT_EN) value the counter
// will hold after this edge, so the top can register it straight onto the bus.
module pixel_conv_counter
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic         tc_c,
  output logic [N-1:0] code_nxt_c
);

  logic [N-1:0] cnt_q, cnt_d;

  assign tc_c = (cnt_q == {N{1'b1}});

  // Next count: clear wins, then increment, holding at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc_c) begin
      cnt_d = cnt_q + N'(1);
    end
  end

  // Bus code for the next count
  always_comb begin
`ifdef GRAY_COUNT_EN
    code_nxt_c = N'(bin2gray(32'(cnt_d)));
`else
    code_nxt_c = cnt_d;
`endif
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, single-slope conversion
// (bus driven with the ramp code), then per-row capture on a valid/ready port.
// Build option: GRAY_COUNT_EN puts Gray code on the bus and decodes captures.
module pixel_readout_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned NUM_ROWS   = 4,
  parameter int unsigned ERASE_CYC  = 5,
  parameter int unsigned EXPOSE_CYC = 255,
  localparam int unsigned ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                erase,
  output logic                expose,
  output logic                ramp_en,
  output logic [N-1:0]        data_out,
  output logic                data_oe,
  input  logic [N-1:0]        data_in,
  output logic [NUM_ROWS-1:0] read,
  output logic [N-1:0]        pix_data,
  output logic [ROW_W-1:0]    pix_row,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned PH_MAX = (ERASE_CYC > EXPOSE_CYC) ? ERASE_CYC : EXPOSE_CYC;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_e              state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [ROW_W-1:0]    row_q, row_d;

  logic                erase_q, erase_d;
  logic                expose_q, expose_d;
  logic                ramp_en_q, ramp_en_d;
  logic [N-1:0]        data_out_q, data_out_d;
  logic                data_oe_q, data_oe_d;
  logic [NUM_ROWS-1:0] read_q, read_d;
  logic [N-1:0]        pix_data_q, pix_data_d;
  logic [ROW_W-1:0]    pix_row_q, pix_row_d;
  logic                pix_valid_q, pix_valid_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic                conv_tc_c;
  logic [N-1:0]        conv_code_c;
  logic [N-1:0]        cap_code_c;

  pixel_conv_counter #(.N(N)) u_conv_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state_q != ST_CONVERT),
    .en         (state_q == ST_CONVERT),
    .tc_c       (conv_tc_c),
    .code_nxt_c (conv_code_c)
  );

  // Bus value as a binary code
  always_comb begin
`ifdef GRAY_COUNT_EN
    cap_code_c = N'(gray2bin(32'(data_in)));
`else
    cap_code_c = data_in;
`endif
  end

  // State, phase counter and row index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      row_q   <= row_d;
    end
  end

  // Next state, phase count and row index
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        ph_d = '0;
        if (start) state_d = ST_ERASE;
      end
      ST_ERASE: begin
        if (ph_q == PH_W'(ERASE_CYC - 1)) begin
          ph_d    = '0;
          state_d = ST_EXPOSE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_EXPOSE: begin
        if (ph_q == PH_W'(EXPOSE_CYC - 1)) begin
          ph_d    = '0;
          state_d = ST_CONVERT;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_CONVERT: begin
        if (conv_tc_c) state_d = ST_GAP;
      end
      ST_GAP: begin
        row_d   = '0;
        state_d = ST_RD_SEL;
      end
      ST_RD_SEL: state_d = ST_RD_CAP;
      ST_RD_CAP: state_d = ST_RD_HOLD;
      ST_RD_HOLD: begin
        if (pix_valid_q && pix_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = ST_RD_SEL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered output values for the coming cycle
  always_comb begin
    erase_d      = (state_d == ST_ERASE);
    expose_d     = (state_d == ST_EXPOSE);
    ramp_en_d    = (state_d == ST_CONVERT);
    data_oe_d    = (state_d == ST_CONVERT);
    data_out_d   = (state_d == ST_CONVERT) ? conv_code_c : '0;
    read_d       = '0;
    pix_data_d   = pix_data_q;
    pix_row_d    = pix_row_q;
    pix_valid_d  = pix_valid_q;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_q == ST_RD_HOLD) && (state_d == ST_IDLE);
    if ((state_d == ST_RD_SEL) || (state_d == ST_RD_CAP)) begin
      read_d = NUM_ROWS'(1) << row_d;
    end
    if (state_q == ST_RD_CAP) begin
      pix_data_d  = cap_code_c;
      pix_row_d   = row_q;
      pix_valid_d = 1'b1;
    end else if ((state_q == ST_RD_HOLD) && pix_valid_q && pix_ready) begin
      pix_valid_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      ramp_en_q    <= 1'b0;
      data_out_q   <= '0;
      data_oe_q    <= 1'b0;
      read_q       <= '0;
      pix_data_q   <= '0;
      pix_row_q    <= '0;
      pix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      ramp_en_q    <= ramp_en_d;
      data_out_q   <= data_out_d;
      data_oe_q    <= data_oe_d;
      read_q       <= read_d;
      pix_data_q   <= pix_data_d;
      pix_row_q    <= pix_row_d;
      pix_valid_q  <= pix_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign ramp_en    = ramp_en_q;
  assign data_out   = data_out_q;
  assign data_oe    = data_oe_q;
  assign read       = read_q;
  assign pix_data   = pix_data_q;
  assign pix_row    = pix_row_q;
  assign pix_valid  = pix_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
